// File: rtl/cac_fns_seq_encoder_pkg.sv
// cac_fns_seq_encoder_pkg: Fibonacci weights, data-width rule and controller state encodings
package cac_fns_seq_encoder_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
   // W[0]=1, W[1]=2, W[i]=W[i-1]+W[i-2]
   function automatic int fib_w(input int i);
      int a, b, t;
      a = 1;
      b = 2;
      for (int j = 0; j < i; j++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction
   // Data width needed to carry every legal input 0..W[n]-1
   function automatic int blen_for(input int n);
      return $clog2(fib_w(n));
   endfunction
endpackage

// File: rtl/cac_fns_step.sv
// cac_fns_step: one greedy FNS digit -- compare, conditional subtract, weight step-down
module cac_fns_step #(
   parameter int WD = 5
) (
   input  logic [WD-1:0] r_i,
   input  logic [WD-1:0] wh_i,
   input  logic [WD-1:0] wl_i,
   output logic          bit_o,
   output logic [WD-1:0] r_next_o,
   output logic [WD-1:0] wh_next_o,
   output logic [WD-1:0] wl_next_o
);
   // Greedy digit: take the current weight whenever the remainder covers it
   always_comb begin
      bit_o     = r_i >= wh_i;
      r_next_o  = bit_o ? r_i - wh_i : r_i;
      wh_next_o = wl_i;
      wl_next_o = wh_i - wl_i;
   end
endmodule

// File: rtl/cac_fns_seq_encoder.sv
// cac_fns_seq_encoder: bit-serial FNS crosstalk-avoidance encoder behind a valid/ready handshake
module cac_fns_seq_encoder
   import cac_fns_seq_encoder_pkg::*;
#(
   parameter int N    = 5,
   parameter int BLEN = 4
) (
   input  logic            clock_i,
   input  logic            reset_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [BLEN-1:0] datain_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [N-1:0]    codeout_o,
   output logic            err_o,
   output logic            busy_o
);
   localparam int WD = BLEN + 1;
   localparam int KW = $clog2(N);
   localparam logic [WD-1:0] W_N   = WD'(fib_w(N));
   localparam logic [WD-1:0] W_NM1 = WD'(fib_w(N - 1));
   localparam logic [WD-1:0] W_NM2 = WD'(fib_w(N - 2));
   localparam logic [KW-1:0] K_TOP = KW'(N - 1);

   state_e          state_q, state_d;
   logic [WD-1:0]   r_q, wh_q, wl_q, r_nx, wh_nx, wl_nx;
   logic [KW-1:0]   k_q;
   logic [N-1:0]    code_q;
   logic            err_q, bit_nx, accept, oor;
   logic [WD-1:0]   din_x;

   assign din_x     = WD'(datain_i);
   assign oor       = din_x >= W_N;
   assign accept    = in_valid_i & in_ready_o;
   assign codeout_o = code_q;
   assign err_o     = err_q;

   cac_fns_step #(.WD(WD)) u_step (
      .r_i       (r_q),
      .wh_i      (wh_q),
      .wl_i      (wl_q),
      .bit_o     (bit_nx),
      .r_next_o  (r_nx),
      .wh_next_o (wh_nx),
      .wl_next_o (wl_nx)
   );

   // State register
   always_ff @(posedge clock_i or posedge reset_i)
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;

   // Next state: an accept (from IDLE or a DONE handover) always restarts the word
   always_comb begin
      state_d = accept ? (oor ? DONE : RUN)
              : state_q == RUN ? (k_q == '0 ? DONE : RUN)
              : (state_q == DONE && out_ready_i) ? IDLE : state_q;
   end

   // Handshake and status outputs decoded from state
   always_comb begin
      in_ready_o  = state_q == IDLE || (state_q == DONE && out_ready_i);
      out_valid_o = state_q == DONE;
      busy_o      = state_q != IDLE;
   end

   // Datapath: load operand and top weights on accept, then emit one digit per RUN edge MSB first
   always_ff @(posedge clock_i or posedge reset_i)
      if (reset_i) begin
         r_q    <= '0;
         wh_q   <= '0;
         wl_q   <= '0;
         k_q    <= '0;
         code_q <= '0;
         err_q  <= 1'b0;
      end else if (accept) begin
         r_q    <= oor ? '0 : din_x;
         wh_q   <= W_NM1;
         wl_q   <= W_NM2;
         k_q    <= K_TOP;
         code_q <= '0;
         err_q  <= oor;
      end else if (state_q == RUN) begin
         r_q         <= r_nx;
         wh_q        <= wh_nx;
         wl_q        <= wl_nx;
         k_q         <= k_q - 1'b1;
         code_q[k_q] <= bit_nx;
      end
endmodule

// File: tb/tb_cac_fns_seq_encoder.sv
// tb_cac_fns_seq_encoder: directed scoreboard bench for the serial FNS encoder
module tb_cac_fns_seq_encoder;
   logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic [3:0] datain = '0;
   logic       in_ready, out_valid, err, busy;
   logic [4:0] codeout;
   int         total = 0, bad = 0, cyc = 0, last_pop = 0;
   bit         seen = 1'b0;

   typedef struct {
      logic [4:0] code;
      logic       err;
      int         d;
      int         lat;
      int         acc;
      int         iv;
   } exp_t;
   exp_t q[$];

   cac_fns_seq_encoder #(.N(5), .BLEN(4)) dut (
      .clock_i     (clk),
      .reset_i     (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .datain_i    (datain),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .codeout_o   (codeout),
      .err_o       (err),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] greedy(input int v);
      int w [0:4] = '{1, 2, 3, 5, 8};
      logic [4:0] c = '0;
      for (int i = 4; i >= 0; i--)
         if (v >= w[i]) begin
            c[i] = 1'b1;
            v -= w[i];
         end
      return c;
   endfunction

   function automatic int wsum(input logic [4:0] c);
      int w [0:4] = '{1, 2, 3, 5, 8};
      int s = 0;
      for (int i = 0; i < 5; i++) if (c[i]) s += w[i];
      return s;
   endfunction

   // Monitor: latency on first out_valid, result check on each output handshake
   always @(negedge clk) begin
      exp_t e;
      if (out_valid) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_out_valid: got codeout=%b err=%b with nothing expected", codeout, err);
         end else begin
            if (!seen) begin
               seen = 1'b1;
               chk("latency", cyc - q[0].acc + 1, q[0].lat);
            end
            if (out_ready) begin
               e = q.pop_front();
               seen = 1'b0;
               chk($sformatf("codeout[d=%0d]", e.d), int'(codeout), int'(e.code));
               chk($sformatf("err[d=%0d]", e.d), int'(err), int'(e.err));
               if (!e.err) begin
                  chk("no_adjacent_ones", int'(codeout & (codeout >> 1)), 0);
                  chk("weight_sum", wsum(codeout), e.d);
               end
               if (e.iv != 0) chk("interval", cyc - last_pop, e.iv);
               last_pop = cyc;
            end
         end
      end
   end

   task automatic send(input int d, input logic [4:0] c, input logic e, input int lat, input int iv);
      int n = 0;
      exp_t x;
      in_valid = 1'b1;
      datain   = 4'(d);
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready stayed 0 for d=%0d", d);
      end else begin
         x.code = c;
         x.err  = e;
         x.d    = d;
         x.lat  = lat;
         x.acc  = cyc + 1;
         x.iv   = iv;
         q.push_back(x);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d results still expected", q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      #2;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_codeout", int'(codeout), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      #20;
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      send(12, 5'b10101, 1'b0, 6, 0);
      send(7, 5'b01010, 1'b0, 6, 6);
      send(6, 5'b01001, 1'b0, 6, 6);
      send(0, 5'b00000, 1'b0, 6, 6);
      send(13, 5'b00000, 1'b1, 1, 0);
      send(4, 5'b00101, 1'b0, 6, 0);
      drain();
      // Backpressure: result must hold while the sink stalls
      out_ready = 1'b0;
      send(9, 5'b10001, 1'b0, 6, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
      chk("bp_out_valid_rise", int'(out_valid), 1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         chk("bp_hold_valid", int'(out_valid), 1);
         chk("bp_hold_code", int'(codeout), int'(5'b10001));
         chk("bp_hold_in_ready", int'(in_ready), 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(10, 5'b10010, 1'b0, 6, 0);
      drain();
      // Reset in the third RUN cycle aborts the word
      send(11, 5'b10100, 1'b0, 6, 0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_codeout", int'(codeout), 0);
      chk("abort_err", int'(err), 0);
      chk("abort_busy", int'(busy), 0);
      q.delete();
      seen = 1'b0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      send(11, 5'b10100, 1'b0, 6, 0);
      drain();
      // Back-to-back stream of every legal value
      for (int d = 0; d <= 12; d++) send(d, greedy(d), 1'b0, 6, d == 0 ? 0 : 6);
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
